// File: rtl/frame_pkt_scheduler_if.sv
// Stream and packet-control bundle between the frame scheduler, the scope
// datapath (word source) and the UDP packet sender.
interface frame_pkt_scheduler_if;
   logic [31:0] i_in_data;
   logic        i_in_vld;
   logic        o_in_rdy;
   logic [31:0] o_out_data;
   logic        o_out_vld;
   logic        i_out_rdy;
   logic        o_pkt_sync;
   logic [15:0] o_pkt_len;

   // Scheduler side
   modport master (
      input  i_in_data, i_in_vld, i_out_rdy,
      output o_in_rdy, o_out_data, o_out_vld, o_pkt_sync, o_pkt_len
   );

   // Source/sender side
   modport slave (
      output i_in_data, i_in_vld, i_out_rdy,
      input  o_in_rdy, o_out_data, o_out_vld, o_pkt_sync, o_pkt_len
   );
endinterface

// File: rtl/frame_pkt_scheduler.sv
// Splits each acquired frame into sender packets: sync + length, gated word
// stream, inter-packet gap. FRAME_HDR_EN adds a leading header word per packet.
module frame_pkt_scheduler #(
   parameter int unsigned MAX_PKT_WORDS = 360,
   parameter int unsigned GAP_CYCLES    = 64,
   parameter int unsigned TIMEOUT       = 65535
) (
   input  logic                         sys_clk,
   input  logic                         rst_n,
   input  logic                         i_frame_ready,
   input  logic [15:0]                  i_frame_size,
   frame_pkt_scheduler_if.master        bus,
   output logic                         o_busy,
   output logic [15:0]                  o_frame_cnt,
   output logic [7:0]                   o_drop_cnt,
   output logic                         o_err_timeout
);

   localparam int unsigned CHUNK_W = 14;
   localparam int unsigned GAP_W   = 16;
   localparam int unsigned STALL_W = 20;

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_SYNC, S_STREAM, S_GAP} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_prev_rdy;
   logic [15:0]          r_remaining;
   logic [CHUNK_W-1:0]   r_chunk;
   logic [15:0]          r_pkt_len;
   logic                 r_pkt_sync;
   logic                 r_busy;
   logic [15:0]          r_frame_cnt;
   logic [7:0]           r_drop_cnt;
   logic                 r_err;
   logic [GAP_W-1:0]     r_gap_cnt;
   logic [STALL_W-1:0]   r_stall;
`ifdef FRAME_HDR_EN
   logic                 r_hdr_pend;
   logic [15:0]          r_pkt_idx;
   logic                 w_hdr_phase;
`endif

   logic                 w_new;
   logic                 w_in_stream;
   logic                 w_data_phase;
   logic                 w_move;
   logic                 w_progress;
   logic                 w_last;
   logic                 w_frame_done;
   logic                 w_stall_hit;
   logic                 w_gap_done;
   logic [CHUNK_W-1:0]   w_chunk_nxt;
   logic [CHUNK_W-1:0]   w_len_words;

   assign w_new       = i_frame_ready & ~r_prev_rdy;
   assign w_in_stream = (r_state == S_STREAM);

`ifdef FRAME_HDR_EN
   // Header word occupies the first STREAM beat; the source is held off meanwhile
   assign w_hdr_phase     = w_in_stream & r_hdr_pend;
   assign w_data_phase    = w_in_stream & ~r_hdr_pend;
   assign bus.o_out_data  = w_hdr_phase ? {8'hA5, r_frame_cnt[7:0], r_pkt_idx} : bus.i_in_data;
   assign bus.o_out_vld   = w_hdr_phase | (bus.i_in_vld & w_data_phase);
   assign w_progress      = w_move | (w_hdr_phase & bus.i_out_rdy);
   assign w_len_words     = CHUNK_W'(w_chunk_nxt + CHUNK_W'(1));
`else
   assign w_data_phase    = w_in_stream;
   assign bus.o_out_data  = bus.i_in_data;
   assign bus.o_out_vld   = bus.i_in_vld & w_data_phase;
   assign w_progress      = w_move;
   assign w_len_words     = w_chunk_nxt;
`endif

   assign bus.o_in_rdy   = bus.i_out_rdy & w_data_phase;
   assign bus.o_pkt_sync = r_pkt_sync;
   assign bus.o_pkt_len  = r_pkt_len;

   assign w_move       = w_data_phase & bus.i_in_vld & bus.i_out_rdy;
   assign w_last       = w_move & (r_chunk == CHUNK_W'(1));
   assign w_frame_done = w_last & (r_remaining == 16'd1);
   assign w_stall_hit  = w_in_stream & ~w_progress & (r_stall == STALL_W'(TIMEOUT - 1));
   assign w_gap_done   = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));
   assign w_chunk_nxt  = (r_remaining > 16'(MAX_PKT_WORDS)) ? CHUNK_W'(MAX_PKT_WORDS)
                                                            : r_remaining[CHUNK_W-1:0];

   assign o_busy        = r_busy;
   assign o_frame_cnt   = r_frame_cnt;
   assign o_drop_cnt    = r_drop_cnt;
   assign o_err_timeout = r_err;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_new && (i_frame_size != 16'd0)) w_state_nxt = S_ARM;
         S_ARM:    w_state_nxt = S_SYNC;
         S_SYNC:   w_state_nxt = S_STREAM;
         S_STREAM: begin
            if (w_stall_hit || w_frame_done) w_state_nxt = S_IDLE;
            else if (w_last)                 w_state_nxt = S_GAP;
         end
         S_GAP:    if (w_gap_done) w_state_nxt = S_ARM;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Frame bookkeeping, packet sizing, gap/stall timers and status counters
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev_rdy  <= 1'b1;
         r_remaining <= '0;
         r_chunk     <= '0;
         r_pkt_len   <= '0;
         r_pkt_sync  <= 1'b0;
         r_busy      <= 1'b0;
         r_frame_cnt <= '0;
         r_drop_cnt  <= '0;
         r_err       <= 1'b0;
         r_gap_cnt   <= '0;
         r_stall     <= '0;
`ifdef FRAME_HDR_EN
         r_hdr_pend  <= 1'b0;
         r_pkt_idx   <= '0;
`endif
      end else begin
         r_prev_rdy <= i_frame_ready;
         r_pkt_sync <= (w_state_nxt == S_SYNC);
         r_busy     <= (w_state_nxt != S_IDLE);

         if ((r_state == S_IDLE) && w_new) begin
            r_remaining <= i_frame_size;
            r_err       <= 1'b0;
`ifdef FRAME_HDR_EN
            r_pkt_idx   <= '0;
`endif
            if (i_frame_size == 16'd0) r_frame_cnt <= r_frame_cnt + 16'd1;
         end

         if ((r_state != S_IDLE) && w_new && (r_drop_cnt != 8'hFF))
            r_drop_cnt <= r_drop_cnt + 8'd1;

         if (r_state == S_ARM) begin
            r_chunk   <= w_chunk_nxt;
            r_pkt_len <= {w_len_words, 2'b00};
`ifdef FRAME_HDR_EN
            r_hdr_pend <= 1'b1;
`endif
         end

`ifdef FRAME_HDR_EN
         if (w_hdr_phase && bus.i_out_rdy) r_hdr_pend <= 1'b0;
         if (w_last)                       r_pkt_idx  <= r_pkt_idx + 16'd1;
`endif

         if (w_move) begin
            r_chunk     <= r_chunk - CHUNK_W'(1);
            r_remaining <= r_remaining - 16'd1;
         end

         if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
         if (w_stall_hit)  r_err       <= 1'b1;

         if (!w_in_stream || w_progress) r_stall <= '0;
         else                            r_stall <= r_stall + STALL_W'(1);

         if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + GAP_W'(1);
         else                  r_gap_cnt <= '0;
      end
   end

endmodule
